regfile16_2r1w: RTL and testbench

- 16-entry, 2-read/1-write register file: the storage stage directly upstream of the per-bit 16:1 read-select muxes in the pipelined CPU's decode stage.
- Holds architectural registers R0–R14; R15 is hardwired to zero.
- Written by the write-back stage; read combinationally by decode.
- Each read port is built as WIDTH instances of mux16_1, one per bit, selected by the read address.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/decoder4_16.sv | 12 +
 rtl/mux16_1.sv | 12 +
 rtl/regfile16_2r1w.sv | 69 ++++++
 tb/tb_regfile16_2r1w.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16-entry register file and its helpers.
package regfile_pkg;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 4'd15;
endpackage

// File: rtl/decoder4_16.sv
// Write-row decoder: one-hot row enable from wr_addr, all rows idle when wr_en is low.
module decoder4_16
  import regfile_pkg::*;
(
  input  logic                wr_en,
  input  reg_addr_t           wr_addr,
  output logic [NUM_REGS-1:0] row_en
);

  assign row_en = wr_en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wr_addr) : '0;

endmodule

// File: rtl/mux16_1.sv
// Single-bit 16:1 read-select mux; one instance per data bit per read port.
module mux16_1
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0] d,
  input  reg_addr_t           sel,
  output logic                y
);

  assign y = d[sel];

endmodule

// File: rtl/regfile16_2r1w.sv
// 16-entry 2-read/1-write register file, R15 hardwired to zero, combinational reads.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile16_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  reg_addr_t        wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  reg_addr_t        rd_addr_a,
  input  reg_addr_t        rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [NUM_REGS-1:0] row_en;
  logic [WIDTH-1:0]    regs [NUM_REGS-1];
  logic [WIDTH-1:0]    mux_a;
  logic [WIDTH-1:0]    mux_b;
  logic                unused_row15;

  decoder4_16 u_dec (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .row_en  (row_en)
  );

  // R15 has no storage, so its row enable goes nowhere.
  assign unused_row15 = row_en[ZERO_REG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS-1; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS-1; r++) begin
        if (row_en[r]) regs[r] <= wr_data;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [NUM_REGS-1:0] col;
    for (genvar r = 0; r < NUM_REGS-1; r++) begin : g_row
      assign col[r] = regs[r][i];
    end
    assign col[ZERO_REG] = 1'b0;

    mux16_1 u_mux_a (.d(col), .sel(rd_addr_a), .y(mux_a[i]));
    mux16_1 u_mux_b (.d(col), .sel(rd_addr_b), .y(mux_b[i]));
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by reset so reads stay 0 while the array is held clear.
  logic hit_a, hit_b;
  always_comb begin
    hit_a = !reset && wr_en && (wr_addr == rd_addr_a) && (wr_addr != ZERO_REG);
    hit_b = !reset && wr_en && (wr_addr == rd_addr_b) && (wr_addr != ZERO_REG);
    rd_data_a = hit_a ? wr_data : mux_a;
    rd_data_b = hit_b ? wr_data : mux_b;
  end
`else
  assign rd_data_a = mux_a;
  assign rd_data_b = mux_b;
`endif

endmodule

// File: tb/tb_regfile16_2r1w.sv
// Randomized scoreboard bench for regfile16_2r1w against an array reference model.
module tb_regfile16_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;

  regfile16_2r1w #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ra;
    logic [3:0]  rb;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [16];
  int          passed = 0;
  int          total  = 0;

  // Architectural read: zero under reset, optional same-cycle forward, else stored value.
  function automatic logic [63:0] exp_rd(input logic [3:0] ra);
    if (reset) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == ra && wr_addr != 4'd15) return wr_data;
`endif
    if (ra == 4'd15) return 64'd0;
    return model[ra];
  endfunction

  task automatic drive(input logic rst, input logic wen, input logic [3:0] wa,
                       input logic [63:0] wd, input logic [3:0] ra, input logic [3:0] rb,
                       input string tag);
    exp_t e;
    reset = rst; wr_en = wen; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    if (rst) for (int r = 0; r < 16; r++) model[r] = 64'd0;
    e.a = exp_rd(ra); e.b = exp_rd(rb); e.ra = ra; e.rb = rb; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    if (!rst && wen && wa != 4'd15) model[wa] = wd;
    #1;
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle against queued expectations.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rd_data_a === e.a) passed++;
      else $display("FAIL %s port_a addr=%0d got=%h exp=%h", e.tag, e.ra, rd_data_a, e.a);
      total++;
      if (rd_data_b === e.b) passed++;
      else $display("FAIL %s port_b addr=%0d got=%h exp=%h", e.tag, e.rb, rd_data_b, e.b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 16; r++) model[r] = 64'd0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    #1;

    // Reset state across several addresses, including a write attempt under reset.
    drive(1, 0, 4'd0, 64'd0, 4'd0, 4'd15, "reset_state");
    drive(1, 1, 4'd3, 64'h55, 4'd3, 4'd14, "reset_state");
    drive(0, 0, 4'd0, 64'd0, 4'd3, 4'd7, "reset_release");

    // Mid-cycle reset after a write clears R3 before any edge; write held under reset is dropped.
    drive(0, 1, 4'd3, 64'hDEAD_BEEF, 4'd0, 4'd1, "wr_r3");
    drive(0, 0, 4'd0, 64'd0, 4'd3, 4'd3, "rd_r3");
    drive(1, 1, 4'd4, 64'hCAFE, 4'd3, 4'd4, "async_reset");
    drive(0, 0, 4'd0, 64'd0, 4'd3, 4'd4, "post_reset");

    // Basic write/read on both ports.
    drive(0, 1, 4'd5, 64'h0123_4567_89AB_CDEF, 4'd0, 4'd1, "wr_r5");
    drive(0, 0, 4'd0, 64'd0, 4'd5, 4'd5, "rd_r5");

    // Zero register, including during the write cycle.
    drive(0, 1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 4'd15, "r15_wr");
    drive(0, 0, 4'd0, 64'd0, 4'd15, 4'd15, "r15_rd");

    // Sweep all storage rows.
    for (int i = 0; i < 15; i++)
      drive(0, 1, 4'(i), 64'(i) * 64'h1111, 4'($urandom_range(0, 15)), 4'd15, "sweep_wr");
    for (int i = 0; i < 15; i++)
      drive(0, 0, 4'd0, 64'd0, 4'(i), 4'(14 - i), "sweep_rd");

    // Same-cycle write/read conflict on R7.
    drive(0, 1, 4'd7, 64'd1, 4'd0, 4'd0, "r7_init");
    drive(0, 1, 4'd7, 64'd2, 4'd7, 4'd7, "r7_conflict");
    drive(0, 0, 4'd0, 64'd0, 4'd7, 4'd7, "r7_after");

    // wr_en low holds state, first with R2 populated, then after reset.
    for (int k = 0; k < 3; k++) drive(0, 0, 4'd2, 64'd9, 4'd2, 4'd2, "wen0_hold");
    drive(1, 0, 4'd0, 64'd0, 4'd2, 4'd2, "wen0_reset");
    for (int k = 0; k < 3; k++) drive(0, 0, 4'd2, 64'd9, 4'd2, 4'd2, "wen0_zero");

    // Back-to-back writes to one register: last write wins.
    drive(0, 1, 4'd9, 64'hA, 4'd9, 4'd0, "b2b_1");
    drive(0, 1, 4'd9, 64'hB, 4'd9, 4'd0, "b2b_2");
    drive(0, 0, 4'd0, 64'd0, 4'd9, 4'd9, "b2b_rd");

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++)
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
            4'($urandom_range(0, 15)), {$urandom, $urandom},
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
